spi_master_arbiter: RTL and testbench
=====================================

Name: spi_master_arbiter

Overview:
Shares one spi_master instance among NUM_REQ independent requesters using round-robin arbitration. For each requester the block latches the transfer descriptor: tx word, target slave, CPOL/CPHA and clock divider. It then drives the master's control inputs, issues a single start pulse and waits for completion. It routes rx_data back with a per-requester done pulse, and a watchdog flags transfers that never complete.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
NUM_SLAVES, 4, slave-select count of the attached master
DATA_WIDTH, 8, SPI word width
TIMEOUT, 65535, cycles allowed in WAIT before abort (must be >= 1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
req  in  NUM_REQ  per-requester request level
req_tx_data  in  NUM_REQ*DATA_WIDTH  packed tx words, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
req_slave_sel  in  NUM_REQ*$clog2(NUM_SLAVES)  packed slave selects
req_cpol  in  NUM_REQ  per-requester CPOL
req_cpha  in  NUM_REQ  per-requester CPHA
req_clk_div  in  NUM_REQ*16  packed clock dividers
gnt  out  NUM_REQ  one-hot owner of the current transfer, 0 when idle
done  out  NUM_REQ  one-cycle completion pulse to the owner
err  out  NUM_REQ  one-cycle timeout pulse to the owner
rx_data  out  DATA_WIDTH  received word, valid in the cycle done is high, held afterwards
busy  out  1  high in START and WAIT
m_tx_data  out  DATA_WIDTH  to master tx_data
m_slave_sel  out  $clog2(NUM_SLAVES)  to master slave_sel
m_cpol  out  1  to master cpol
m_cpha  out  1  to master cpha
m_clk_div  out  16  to master clk_div
m_start  out  1  to master start_transfer
m_rx_data  in  DATA_WIDTH  from master rx_data
m_done  in  1  from master transfer_done
m_busy  in  1  from master busy

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. All registers are cleared on the clk edge where rst=1.
- Reset values: every output is 0. This includes gnt, done, err, rx_data, busy, all m_* outputs and m_start. Also: state=IDLE, rr_ptr=0, timeout counter=0.
- Reset in START or WAIT drops m_start and gnt immediately. No done or err pulse is produced for the dropped transfer.
- All outputs are registered.
- FSM has three states: IDLE, START, WAIT.
- IDLE:
  - Arbitrates only when |req=1 and m_busy=0.
  - Winner is the first requester with req set, searching from index rr_ptr upward, modulo NUM_REQ.
  - On the same edge the block loads the winner's descriptor into the m_tx_data, m_slave_sel, m_cpol, m_cpha and m_clk_div registers, sets gnt to the winner's one-hot, and moves to START.
  - If m_busy=1 (e.g. after a timeout), the block stays in IDLE and does not grant.
- START:
  - m_start=1 for exactly this one cycle.
  - Next state is WAIT and the timeout counter is cleared.
  - The m_* descriptor outputs stay stable from START until the next grant.
- WAIT:
  - If m_done=1: rx_data<=m_rx_data, done[owner]<=1 for one cycle, gnt<=0, rr_ptr<=owner+1 (wraps to 0 after NUM_REQ-1), next state IDLE.
  - Otherwise the counter increments. When the counter reaches TIMEOUT-1 without m_done: err[owner]<=1 for one cycle, gnt<=0, rr_ptr<=owner+1, next state IDLE.
  - m_done and the timeout on the same cycle: m_done wins, done is pulsed and err is not.
- Latency:
  - req seen in IDLE at cycle 0 gives gnt and descriptor at cycle 1, with m_start high in cycle 1.
  - m_done at cycle k gives done/rx_data at cycle k+1.
  - Minimum gap between consecutive m_start pulses is m_done cycle + 2.
- Handshake:
  - A requester holds req and its descriptor until it sees done or err for its own index.
  - The descriptor is sampled only on the grant edge, so later changes do not affect the transfer in flight.
  - Dropping req during START or WAIT does not cancel the transfer; done/err is still pulsed.
- Fairness:
  - A requester that keeps req high is re-granted only after every other pending requester has been served once.
  - A single requester can be served back-to-back.
- m_done seen while in IDLE or START is ignored.
- done and err are never high together, and at most one bit of each is high in any cycle.

Test Plan:
1. Single request. NUM_REQ=4, req=0001, tx=0xA5, sel=2, cpol=0, cpha=0, div=3; spi_master loopback MISO=MOSI -> gnt=0001 at cycle 1, m_start one cycle, done=0001 and rx_data=0xA5 one cycle after m_done; master cs_n=1011 during the transfer.
2. Round-robin. req=1111 held, tx_i=0x10+i -> grant order 0,1,2,3,0, each done with the matching rx_data; no m_start while m_busy=1.
3. Mode and divider switch. Requester 1 uses cpol=1/cpha=1/div=0, requester 2 uses cpol=0/cpha=1/div=5 -> m_cpol, m_cpha and m_clk_div change only on grant edges, and both words are received correctly.
4. Timeout. Stub master with m_done tied 0, TIMEOUT=20, req=0100 -> err=0100 pulse exactly 20 cycles after entering WAIT, done stays 0, no re-grant while the stub holds m_busy=1.
5. Simultaneous events and drop. m_done on the TIMEOUT-1 cycle -> done pulsed, err=0. Requester deasserts req during WAIT -> done still pulsed, and the next grant goes to a different pending requester.
6. Reset mid-transfer. Assert rst during WAIT -> next cycle all outputs are 0 and state is IDLE, no done or err pulse, and arbitration restarts from index 0.

Source files
------------

// File: rtl/spi_master_arbiter.sv
// Round-robin arbiter that shares one SPI master among NUM_REQ requesters.
// Latches the winner's descriptor, issues one start pulse, returns rx data or a timeout.
module spi_master_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int NUM_SLAVES = 4,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 65535
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [NUM_REQ-1:0]                       req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]            req_tx_data,
  input  logic [NUM_REQ*$clog2(NUM_SLAVES)-1:0]    req_slave_sel,
  input  logic [NUM_REQ-1:0]                       req_cpol,
  input  logic [NUM_REQ-1:0]                       req_cpha,
  input  logic [NUM_REQ*16-1:0]                    req_clk_div,
  output logic [NUM_REQ-1:0]                       gnt,
  output logic [NUM_REQ-1:0]                       done,
  output logic [NUM_REQ-1:0]                       err,
  output logic [DATA_WIDTH-1:0]                    rx_data,
  output logic                                     busy,
  output logic [DATA_WIDTH-1:0]                    m_tx_data,
  output logic [$clog2(NUM_SLAVES)-1:0]            m_slave_sel,
  output logic                                     m_cpol,
  output logic                                     m_cpha,
  output logic [15:0]                              m_clk_div,
  output logic                                     m_start,
  input  logic [DATA_WIDTH-1:0]                    m_rx_data,
  input  logic                                     m_done,
  input  logic                                     m_busy
);

  localparam int SW = $clog2(NUM_SLAVES);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);
  localparam logic [IW-1:0] LAST    = IW'(NUM_REQ - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT} state_t;

  state_t                r_state, w_state_nxt;
  logic [IW-1:0]         r_rr, w_rr_nxt;
  logic [IW-1:0]         r_owner, w_owner_nxt;
  logic [CW-1:0]         r_cnt, w_cnt_nxt;
  logic [NUM_REQ-1:0]    r_gnt, w_gnt_nxt;
  logic [NUM_REQ-1:0]    r_done, w_done_nxt;
  logic [NUM_REQ-1:0]    r_err, w_err_nxt;
  logic [DATA_WIDTH-1:0] r_rx, w_rx_nxt;
  logic                  r_busy, w_busy_nxt;
  logic                  r_start, w_start_nxt;
  logic [DATA_WIDTH-1:0] r_tx, w_tx_nxt;
  logic [SW-1:0]         r_sel, w_sel_nxt;
  logic                  r_cpol, w_cpol_nxt;
  logic                  r_cpha, w_cpha_nxt;
  logic [15:0]           r_div, w_div_nxt;

  logic                  w_found;
  logic [IW-1:0]         w_win;
  logic [IW-1:0]         w_rr_inc;

  // First requesting index at or above the round-robin pointer, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_found && req[(int'(r_rr) + k) % NUM_REQ]) begin
        w_found = 1'b1;
        w_win   = IW'((int'(r_rr) + k) % NUM_REQ);
      end
    end
  end

  assign w_rr_inc = (r_owner == LAST) ? '0 : r_owner + IW'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_rr_nxt    = r_rr;
    w_owner_nxt = r_owner;
    w_cnt_nxt   = r_cnt;
    w_gnt_nxt   = r_gnt;
    w_done_nxt  = '0;
    w_err_nxt   = '0;
    w_rx_nxt    = r_rx;
    w_busy_nxt  = r_busy;
    w_start_nxt = 1'b0;
    w_tx_nxt    = r_tx;
    w_sel_nxt   = r_sel;
    w_cpol_nxt  = r_cpol;
    w_cpha_nxt  = r_cpha;
    w_div_nxt   = r_div;
    unique case (r_state)
      S_IDLE: begin
        if (w_found && !m_busy) begin
          w_state_nxt = S_START;
          w_owner_nxt = w_win;
          w_gnt_nxt   = NUM_REQ'(1) << w_win;
          w_busy_nxt  = 1'b1;
          w_start_nxt = 1'b1;
          w_tx_nxt    = req_tx_data[int'(w_win)*DATA_WIDTH +: DATA_WIDTH];
          w_sel_nxt   = req_slave_sel[int'(w_win)*SW +: SW];
          w_cpol_nxt  = req_cpol[w_win];
          w_cpha_nxt  = req_cpha[w_win];
          w_div_nxt   = req_clk_div[int'(w_win)*16 +: 16];
        end
      end
      S_START: begin
        w_state_nxt = S_WAIT;
        w_cnt_nxt   = '0;
      end
      S_WAIT: begin
        // Completion takes priority over a watchdog expiring on the same cycle.
        if (m_done) begin
          w_rx_nxt    = m_rx_data;
          w_done_nxt  = r_gnt;
          w_gnt_nxt   = '0;
          w_busy_nxt  = 1'b0;
          w_rr_nxt    = w_rr_inc;
          w_state_nxt = S_IDLE;
        end else if (r_cnt == CNT_MAX) begin
          w_err_nxt   = r_gnt;
          w_gnt_nxt   = '0;
          w_busy_nxt  = 1'b0;
          w_rr_nxt    = w_rr_inc;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_rr    <= '0;
      r_owner <= '0;
      r_cnt   <= '0;
      r_gnt   <= '0;
      r_done  <= '0;
      r_err   <= '0;
      r_rx    <= '0;
      r_busy  <= 1'b0;
      r_start <= 1'b0;
      r_tx    <= '0;
      r_sel   <= '0;
      r_cpol  <= 1'b0;
      r_cpha  <= 1'b0;
      r_div   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_rr    <= w_rr_nxt;
      r_owner <= w_owner_nxt;
      r_cnt   <= w_cnt_nxt;
      r_gnt   <= w_gnt_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
      r_rx    <= w_rx_nxt;
      r_busy  <= w_busy_nxt;
      r_start <= w_start_nxt;
      r_tx    <= w_tx_nxt;
      r_sel   <= w_sel_nxt;
      r_cpol  <= w_cpol_nxt;
      r_cpha  <= w_cpha_nxt;
      r_div   <= w_div_nxt;
    end
  end

  assign gnt         = r_gnt;
  assign done        = r_done;
  assign err         = r_err;
  assign rx_data     = r_rx;
  assign busy        = r_busy;
  assign m_tx_data   = r_tx;
  assign m_slave_sel = r_sel;
  assign m_cpol      = r_cpol;
  assign m_cpha      = r_cpha;
  assign m_clk_div   = r_div;
  assign m_start     = r_start;

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Bench for spi_master_arbiter: directed table, corner sequences, random traffic.
// The SPI master is emulated by driving m_busy/m_done/m_rx_data directly.
module tb_spi_master_arbiter;

  localparam int N  = 4;
  localparam int TO = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_tx_data;
  logic [7:0]  req_slave_sel;
  logic [3:0]  req_cpol;
  logic [3:0]  req_cpha;
  logic [63:0] req_clk_div;
  logic [3:0]  gnt, done, err;
  logic [7:0]  rx_data;
  logic        busy;
  logic [7:0]  m_tx_data;
  logic [1:0]  m_slave_sel;
  logic        m_cpol, m_cpha;
  logic [15:0] m_clk_div;
  logic        m_start;
  logic [7:0]  m_rx_data;
  logic        m_done;
  logic        m_busy;

  spi_master_arbiter #(
    .NUM_REQ(N), .NUM_SLAVES(4), .DATA_WIDTH(8), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .req(req),
    .req_tx_data(req_tx_data), .req_slave_sel(req_slave_sel),
    .req_cpol(req_cpol), .req_cpha(req_cpha), .req_clk_div(req_clk_div),
    .gnt(gnt), .done(done), .err(err), .rx_data(rx_data), .busy(busy),
    .m_tx_data(m_tx_data), .m_slave_sel(m_slave_sel),
    .m_cpol(m_cpol), .m_cpha(m_cpha), .m_clk_div(m_clk_div),
    .m_start(m_start), .m_rx_data(m_rx_data),
    .m_done(m_done), .m_busy(m_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    int          lat;
    logic [7:0]  tx;
    logic [1:0]  sel;
    bit          cpol;
    bit          cpha;
    logic [15:0] div;
    logic [3:0]  exp_gnt;
    bit          exp_err;
    bit          drop;
    bit          early;
  } vec_t;

  vec_t       tbl[11];
  int         checks = 0;
  int         errors = 0;
  int         rr_model = 0;
  logic [7:0] last_rx = 8'h00;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    logic pb;
    logic bad;
    pb = m_busy;
    @(posedge clk);
    #1;
    bad = !$onehot0(done) || !$onehot0(err) || !$onehot0(gnt) ||
          ((|done) && (|err)) || (m_start && pb);
    chk("invariant", bad, 0);
  endtask

  function automatic int winner(input logic [3:0] m, input int p);
    for (int k = 0; k < N; k++)
      if (m[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic logic [27:0] dut_desc();
    return {m_tx_data, m_slave_sel, m_cpol, m_cpha, m_clk_div};
  endfunction

  task automatic scramble();
    req_tx_data   = $urandom;
    req_slave_sel = 8'($urandom);
    req_cpol      = 4'($urandom);
    req_cpha      = 4'($urandom);
    req_clk_div   = {$urandom, $urandom};
  endtask

  task automatic xfer(input logic [3:0] mask, input int lat,
                      input logic [7:0] rx, input bit drop, input bit early,
                      input logic [3:0] exp_gnt, input bit exp_err);
    int          n;
    int          idx;
    logic [27:0] exp_desc;
    idx = $clog2(exp_gnt);
    exp_desc = {req_tx_data[idx*8 +: 8], req_slave_sel[idx*2 +: 2],
                req_cpol[idx], req_cpha[idx], req_clk_div[idx*16 +: 16]};
    req = mask;
    n = 0;
    do begin
      tick();
      n++;
      if (!m_start)
        chk("idle_quiet", {rx_data, done, err, gnt}, {last_rx, 12'h000});
    end while (!m_start && n < 8);
    chk("grant_latency", n, 1);
    if (!m_start) return;
    chk("gnt", gnt, exp_gnt);
    chk("busy_start", busy, 1);
    chk("desc_grant", dut_desc(), exp_desc);
    m_busy = 1'b1;
    m_done = early;
    m_rx_data = 8'($urandom);
    tick();
    m_done = 1'b0;
    chk("start_one_cycle", {m_start, busy, gnt, done, err},
        {1'b0, 1'b1, exp_gnt, 8'h00});
    if (drop) req = mask & ~exp_gnt;
    scramble();
    if (!exp_err) begin
      repeat (lat) begin
        tick();
        chk("wait_quiet", {done, err, gnt}, {8'h00, exp_gnt});
      end
      m_done = 1'b1;
      m_rx_data = rx;
      m_busy = 1'b0;
      tick();
      m_done = 1'b0;
      m_rx_data = 8'($urandom);
      chk("done", done, exp_gnt);
      chk("no_err_on_done", err, 0);
      chk("rx_data", rx_data, rx);
      chk("release", {gnt, busy}, 0);
      chk("desc_hold", dut_desc(), exp_desc);
      last_rx = rx;
    end else begin
      n = 0;
      do begin
        tick();
        n++;
        if (err == 0) chk("timeout_no_done", done, 0);
      end while (err == 0 && n < TO + 5);
      chk("timeout_cycles", n, TO);
      chk("err", err, exp_gnt);
      chk("no_done_on_err", done, 0);
      chk("release_err", {gnt, busy}, 0);
      chk("desc_hold_err", dut_desc(), exp_desc);
      repeat (3) begin
        tick();
        chk("busy_blocks_grant", {gnt, m_start, err, done}, 0);
      end
      m_busy = 1'b0;
    end
    rr_model = (idx + 1) % N;
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    int w;
    logic [3:0] m;
    int lat;
    tbl[0]  = '{4'b0001,   3, 8'hA5, 2'd2, 0, 0, 16'd3,    4'b0001, 0, 0, 0};
    tbl[1]  = '{4'b1111,   0, 8'h11, 2'd1, 1, 1, 16'd0,    4'b0010, 0, 0, 0};
    tbl[2]  = '{4'b1111,   5, 8'h12, 2'd3, 0, 1, 16'd5,    4'b0100, 0, 0, 0};
    tbl[3]  = '{4'b1111,   2, 8'h13, 2'd0, 1, 0, 16'd7,    4'b1000, 0, 0, 0};
    tbl[4]  = '{4'b1111,   1, 8'h10, 2'd2, 0, 0, 16'd1,    4'b0001, 0, 0, 0};
    tbl[5]  = '{4'b1001,   4, 8'h3C, 2'd1, 0, 1, 16'd2,    4'b1000, 0, 0, 0};
    tbl[6]  = '{4'b0100, 255, 8'h66, 2'd3, 1, 1, 16'hFFFF, 4'b0100, 1, 0, 0};
    tbl[7]  = '{4'b0110,  19, 8'h77, 2'd0, 0, 0, 16'd9,    4'b0010, 0, 0, 0};
    tbl[8]  = '{4'b0110,   2, 8'h5A, 2'd1, 1, 0, 16'd4,    4'b0100, 0, 1, 0};
    tbl[9]  = '{4'b0010,   0, 8'hC3, 2'd2, 0, 1, 16'd6,    4'b0010, 0, 0, 1};
    tbl[10] = '{4'b0010,   1, 8'h3E, 2'd3, 1, 1, 16'd8,    4'b0010, 0, 0, 0};

    rst = 1'b1;
    req = '0;
    m_done = 1'b0;
    m_busy = 1'b0;
    m_rx_data = 8'h00;
    scramble();
    tick();
    tick();
    chk("reset_ctrl", {gnt, done, err, busy, m_start, m_cpol, m_cpha}, 0);
    chk("reset_data", {rx_data, m_tx_data, m_slave_sel, m_clk_div}, 0);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      w = $clog2(tbl[i].exp_gnt);
      req_tx_data[w*8 +: 8]    = tbl[i].tx;
      req_slave_sel[w*2 +: 2]  = tbl[i].sel;
      req_cpol[w]              = tbl[i].cpol;
      req_cpha[w]              = tbl[i].cpha;
      req_clk_div[w*16 +: 16]  = tbl[i].div;
      xfer(tbl[i].req, tbl[i].lat, tbl[i].tx, tbl[i].drop, tbl[i].early,
           tbl[i].exp_gnt, tbl[i].exp_err);
    end

    req = 4'b1000;
    w = 0;
    do begin tick(); w++; end while (!m_start && w < 8);
    chk("rst_seq_grant", gnt, 4'b1000);
    m_busy = 1'b1;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    chk("midrst_ctrl", {gnt, done, err, busy, m_start, m_cpol, m_cpha}, 0);
    chk("midrst_data", {rx_data, m_tx_data, m_slave_sel, m_clk_div}, 0);
    rst = 1'b0;
    m_busy = 1'b0;
    req = '0;
    m_done = 1'b1;
    m_rx_data = 8'hEE;
    tick();
    m_done = 1'b0;
    chk("idle_ignores_mdone", {done, err, gnt, rx_data}, 0);
    last_rx = 8'h00;
    rr_model = 0;
    xfer(4'b1111, 2, 8'h99, 0, 0, 4'b0001, 0);

    for (int i = 0; i < 40; i++) begin
      m = 4'($urandom_range(1, 15));
      lat = $urandom_range(0, 23);
      w = winner(m, rr_model);
      xfer(m, lat, 8'($urandom), 1'($urandom), 1'($urandom),
           4'(1 << w), lat >= TO);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
